// File: rtl/mem_rr_arbiter.sv
// Two-client round-robin arbiter/sequencer in front of a registered-read word memory.
// Define ARB_FIXED_PRIO_EN to make client 0 always win when both clients request.
module mem_rr_arbiter #(
   parameter int ADDR_W = 1,
   parameter int DATA_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        dbg_state
);

   // Handshake: a client holds req/we/addr/wdata until it samples gnt=1 at a
   // posedge; gnt is a one-cycle pulse during ISSUE and rvalid a one-cycle pulse
   // two cycles after gnt for reads.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              win;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      win         = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
`ifdef ARB_FIXED_PRIO_EN
               win = !req0;
`else
               win = (req0 && req1) ? ~last_q : req1;
`endif
               // last_q doubles as the routing index for gnt and read return
               last_d      = win;
               state_d     = ISSUE;
               gnt0_d      = !win;
               gnt1_d      = win;
               mem_we_d    = win ? we1 : we0;
               mem_addr_d  = win ? addr1 : addr0;
               mem_wdata_d = win ? wdata1 : wdata0;
            end
         end
         ISSUE: begin
            state_d = mem_we_q ? IDLE : WAIT;
         end
         WAIT: begin
            state_d = IDLE;
            if (last_q) begin
               rdata1_d  = mem_rdata;
               rvalid1_d = 1'b1;
            end else begin
               rdata0_d  = mem_rdata;
               rvalid0_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: reset, round-robin alternation, write/read
// round trips through a small memory model, and reset aborting ISSUE/WAIT.
module tb_mem_rr_arbiter;

   localparam int ADDR_W = 1;
   localparam int DATA_W = 4;

   logic              clock;
   logic              reset;
   logic              req0, we0, req1, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1, rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic [1:0]        dbg_state;

   int vectors    = 0;
   int miscompares = 0;
   logic [DATA_W-1:0] exp_q[$];

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   mem_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   // memory model: write on posedge, registered read, optional read override
   logic [DATA_W-1:0] mem_model [2**ADDR_W];
   logic [DATA_W-1:0] mem_rd_r;
   logic              force_en;
   logic [DATA_W-1:0] force_val;

   always @(posedge clock) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      mem_rd_r <= mem_model[mem_addr];
   end
   assign mem_rdata = force_en ? force_val : mem_rd_r;

   // driver tasks
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive0(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
   endtask

   task automatic drive1(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      force_en  = 1'b0;
      force_val = '0;
      reset     = 1'b0;
      drive0(1'b1, 1'b1, 1'b0, 4'h3);
      drive1(1'b1, 1'b1, 1'b1, 4'h6);

      // reset held with both requests pending: nothing may happen
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_gnt0", gnt0, 0);
         chk("rst_gnt1", gnt1, 0);
         chk("rst_mem_we", mem_we, 0);
      end
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rvalid1", rvalid1, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      reset = 1'b1;

      // both clients writing continuously: grants alternate 0,1,0,1
      for (int i = 0; i < 8; i++) begin
         step();
         chk("rr_gnt0", gnt0, (i % 4 == 0) ? 1 : 0);
         chk("rr_gnt1", gnt1, (i % 4 == 2) ? 1 : 0);
         chk("rr_overlap", gnt0 & gnt1, 0);
         chk("rr_mem_we", mem_we, (i % 2 == 0) ? 1 : 0);
      end

      // client 0 writes A to addr 1
      drive0(1'b1, 1'b1, 1'b1, 4'hA);
      drive1(1'b0, 1'b0, 1'b0, 4'h0);
      step();
      chk("wr_gnt0", gnt0, 1);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, 1);
      chk("wr_mem_wdata", mem_wdata, 4'hA);
      step();
      chk("wr_gnt0_pulse", gnt0, 0);
      chk("wr_mem_we_off", mem_we, 0);

      // client 0 reads addr 1 back
      drive0(1'b1, 1'b0, 1'b1, 4'h0);
      exp_q.push_back(4'hA);
      step();
      chk("rd0_gnt0", gnt0, 1);
      chk("rd0_mem_we", mem_we, 0);
      chk("rd0_mem_addr", mem_addr, 1);
      step();
      drive0(1'b0, 1'b0, 1'b0, 4'h0);
      chk("rd0_wait_rvalid0", rvalid0, 0);
      chk("rd0_wait_gnt0", gnt0, 0);
      step();
      chk("rd0_rvalid0", rvalid0, 1);
      chk("rd0_rdata0", rdata0, exp_q.pop_front());
      chk("rd0_rvalid1", rvalid1, 0);
      step();
      chk("rd0_rvalid0_pulse", rvalid0, 0);
      chk("rd0_rdata0_hold", rdata0, 4'hA);

      // client 1 reads addr 0 with the memory returning 5
      force_en  = 1'b1;
      force_val = 4'h5;
      drive1(1'b1, 1'b0, 1'b0, 4'h0);
      exp_q.push_back(4'h5);
      step();
      chk("rd1_gnt1", gnt1, 1);
      chk("rd1_gnt0", gnt0, 0);
      chk("rd1_mem_addr", mem_addr, 0);
      step();
      drive1(1'b0, 1'b0, 1'b0, 4'h0);
      step();
      chk("rd1_rvalid1", rvalid1, 1);
      chk("rd1_rdata1", rdata1, exp_q.pop_front());
      chk("rd1_rvalid0", rvalid0, 0);
      chk("rd1_rdata0_kept", rdata0, 4'hA);
      step();
      chk("rd1_rvalid1_pulse", rvalid1, 0);
      force_en = 1'b0;

      // reset during WAIT of a client 0 read
      drive0(1'b1, 1'b0, 1'b0, 4'h0);
      step();
      chk("abort_gnt0", gnt0, 1);
      step();
      drive0(1'b0, 1'b0, 1'b0, 4'h0);
      reset = 1'b0;
      #1;
      chk("abort_rvalid0_async", rvalid0, 0);
      chk("abort_rdata0_clr", rdata0, 0);
      chk("abort_rdata1_clr", rdata1, 0);
      chk("abort_state", dbg_state, 0);
      step();
      chk("abort_rvalid0", rvalid0, 0);
      reset = 1'b1;
      drive1(1'b1, 1'b1, 1'b1, 4'h9);
      step();
      chk("post_gnt1", gnt1, 1);
      chk("post_rvalid0", rvalid0, 0);
      chk("post_mem_we", mem_we, 1);
      chk("post_mem_wdata", mem_wdata, 4'h9);
      step();
      drive1(1'b0, 1'b0, 1'b0, 4'h0);
      chk("post_gnt1_pulse", gnt1, 0);

      // reset during ISSUE of a write suppresses the memory write
      drive0(1'b1, 1'b1, 1'b0, 4'hF);
      step();
      chk("sup_gnt0", gnt0, 1);
      chk("sup_mem_we", mem_we, 1);
      drive0(1'b0, 1'b0, 1'b0, 4'h0);
      reset = 1'b0;
      #1;
      chk("sup_mem_we_clr", mem_we, 0);
      step();
      reset = 1'b1;
      drive0(1'b1, 1'b0, 1'b0, 4'h0);
      exp_q.push_back(4'h3);
      step();
      chk("sup_rd_gnt0", gnt0, 1);
      step();
      drive0(1'b0, 1'b0, 1'b0, 4'h0);
      step();
      chk("sup_rd_rvalid0", rvalid0, 1);
      chk("sup_rd_rdata0", rdata0, exp_q.pop_front());
      step();

`ifdef ARB_FIXED_PRIO_EN
      // fixed priority: client 0 starves client 1 while it keeps requesting
      drive0(1'b1, 1'b1, 1'b0, 4'h1);
      drive1(1'b1, 1'b1, 1'b1, 4'h2);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("fp_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
         chk("fp_gnt1", gnt1, 0);
      end
      drive0(1'b0, 1'b0, 1'b0, 4'h0);
      step();
      chk("fp_gnt1_after", gnt1, 1);
      step();
      drive1(1'b0, 1'b0, 1'b0, 4'h0);
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
